rc5_key_expander: RTL and testbench
===================================

// Module: rc5_key_expander
// PURPOSE
//  RC5-16/r/16 key schedule generator: expands a 128-bit user key into t=2*(r+1) 16-bit subkeys S[0..t-1].
//  Producer side of the subkey table consumed by the algo encrypt/decrypt core, which reads S[2i], S[2i+1] per round.
//  Iterative, one table operation per cycle; subkeys are exposed through a registered read port.
// PARAMETERS
//  MAX_ROUNDS  16      max r supported; table depth = 2*(MAX_ROUNDS+1) = 34
//  P16         16'hB7E1 magic constant P for w=16
//  Q16         16'h9E37 magic constant Q for w=16
// PORTS
//  clk          in   1    clock
//  rst          in   1    reset, synchronous, active-low
//  start        in   1    request expansion; sampled only in IDLE
//  key          in   128  user key; L[i] = key[16i+15:16i], i=0..7; sampled on accepted start
//  num_rounds   in   5    r, 0..MAX_ROUNDS; sampled on accepted start; r>MAX_ROUNDS clamps to MAX_ROUNDS
//  busy         out  1    high from cycle after accepted start until done cycle inclusive
//  done         out  1    one-cycle pulse: table complete
//  sk_valid     out  1    table valid; set with done, cleared on accepted start or reset
//  sk_count     out  6    t latched for current table
//  sk_rd_addr   in   6    subkey index
//  sk_rd_data   out  16   S[sk_rd_addr], registered (1-cycle latency)
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, sk_valid=0, sk_count=0, sk_rd_data=0; i, j, A, B counters = 0.
//  States: IDLE -> LOAD -> INIT -> MIX -> FIN -> IDLE.
//   IDLE: start=1 -> LOAD; latch key into L[0..7], t=2*(r+1), n=3*max(t,8); clear sk_valid.
//   LOAD: 1 cycle; S[0]=P16, k=1.
//   INIT: S[k]=S[k-1]+Q16 (mod 2^16), one per cycle, k=1..t-1; t-1 cycles; 0 cycles skipped never (t>=2).
//   MIX: n cycles, i=j=A=B=0 at entry; each cycle:
//        A' = rotl16(S[i]+A+B, 3); B' = rotl16(L[j]+A'+B, (A'+B)[3:0]);
//        S[i]=A'; L[j]=B'; A=A'; B=B'; i=(i==t-1)?0:i+1; j=(j+1) mod 8.
//   FIN: 1 cycle; done=1, sk_valid=1, busy=0 next cycle.
//  Arithmetic: all adds mod 2^16; rotate amount uses low 4 bits only.
//  Latency: start to done = 1(LOAD)+(t-1)(INIT)+n(MIX)+1(FIN)+1 accept = t+n+2 cycles.
//   r=12: t=26,n=78 -> done 106 cycles after start sample edge; r=0: t=2,n=24 -> 28.
//  start while busy: ignored, no effect on in-flight expansion. start and done same cycle: start ignored.
//  Read port: sk_rd_data <= (sk_valid && sk_rd_addr<t) ? S[sk_rd_addr] : 16'h0; reads during busy return 0.
//  key/num_rounds changes after acceptance have no effect.
//  Reset mid-operation: abort, return to IDLE, sk_valid=0; table contents undefined unless zeroize enabled.
// CONFIGURATION
//  RC5_KEY_ZEROIZE_EN defined: FIN additionally clears L[0..7], A, B to 0; reset clears all S[] and L[] to 0;
//   read of any address after reset returns 0. Latency unchanged.
//  Undefined: L[], A, B retain key-derived values after FIN; S[]/L[] not reset (control regs only).
// TESTING
//  Golden model: C RC5-16 key expansion; compare full table via read port after every done.
//  T1 key=0, r=0, start -> done at cycle 28, sk_count=2, S[0..1] match model; S[0] first MIX write = 16'hBF0D.
//  T2 key=128'h0F0E..0100 bytes 00..0F, r=12 -> done at cycle 106, sk_count=26, all 26 words match model.
//  T3 r=16, random key -> sk_count=34; read addr 34 and 63 -> sk_rd_data=0; addr 33 matches model.
//  T4 start pulsed every cycle while busy with different key -> table reflects first key only, single done pulse.
//  T5 rst=0 at MIX cycle 10 -> next cycle busy=0, sk_valid=0; new start completes with correct table.
//  T6 num_rounds=31 -> clamps to r=16, t=34; with RC5_KEY_ZEROIZE_EN, post-reset reads of addr 0..33 = 0.

Source files
------------

// File: rtl/rc5_key_expander.sv
// rc5_key_expander: iterative RC5-16/r/16 key schedule generator with a registered subkey read port.
// Build option RC5_KEY_ZEROIZE_EN: wipe L/A/B at FIN and clear S/L tables on reset.
module rc5_key_expander #(
    parameter int          MAX_ROUNDS = 16,
    parameter logic [15:0] P16        = 16'hB7E1,
    parameter logic [15:0] Q16        = 16'h9E37
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [4:0]   num_rounds,
    output logic         busy,
    output logic         done,
    output logic         sk_valid,
    output logic [5:0]   sk_count,
    input  logic [5:0]   sk_rd_addr,
    output logic [15:0]  sk_rd_data
);
    localparam int DEPTH = 2 * (MAX_ROUNDS + 1);
    typedef enum logic [2:0] {IDLE, LOAD, INIT, MIX, FIN} state_t;
    state_t      state_q, state_d;
    logic        busy_q, busy_d, done_q, done_d, valid_q, valid_d;
    logic [5:0]  t_q, t_d, i_q, i_d;
    logic [6:0]  n_q, n_d, cnt_q, cnt_d;
    logic [2:0]  j_q, j_d;
    logic [15:0] a_q, a_d, b_q, b_d, rd_q, rd_d;
    logic [15:0] s_q [DEPTH];
    logic [15:0] s_d [DEPTH];
    logic [15:0] l_q [8];
    logic [15:0] l_d [8];
    logic [4:0]  r_c;
    logic [5:0]  t_n, t_m;
    logic [15:0] a_n, ab, b_n;

    function automatic logic [15:0] rotl(input logic [15:0] x, input logic [3:0] s);
        logic [31:0] y;
        y = {x, x} << s;
        return y[31:16];
    endfunction

    always_comb begin
        r_c     = (num_rounds > 5'(MAX_ROUNDS)) ? 5'(MAX_ROUNDS) : num_rounds;
        t_n     = {r_c + 5'd1, 1'b0};
        t_m     = (t_n < 6'd8) ? 6'd8 : t_n;
        a_n     = rotl(s_q[i_q] + a_q + b_q, 4'd3);
        ab      = a_n + b_q;
        b_n     = rotl(l_q[j_q] + ab, ab[3:0]);
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        t_d     = t_q;
        n_d     = n_q;
        i_d     = i_q;
        j_d     = j_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        l_d     = l_q;
        rd_d    = (valid_q && sk_rd_addr < t_q) ? s_q[sk_rd_addr] : 16'h0;
        case (state_q)
            IDLE: begin
                // busy is still high during the done cycle, so a start there is dropped
                if (done_q) begin
                    busy_d = 1'b0;
                end else if (start) begin
                    state_d = LOAD;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    t_d     = t_n;
                    n_d     = {1'b0, t_m} + {t_m, 1'b0};
                    for (int k = 0; k < 8; k++) l_d[k] = key[16*k +: 16];
                end
            end
            LOAD: begin
                s_d[0]  = P16;
                i_d     = 6'd1;
                state_d = INIT;
            end
            INIT: begin
                s_d[i_q] = s_q[i_q - 6'd1] + Q16;
                i_d      = i_q + 6'd1;
                if (i_q == t_q - 6'd1) begin
                    state_d = MIX;
                    i_d     = 6'd0;
                    j_d     = 3'd0;
                    a_d     = 16'h0;
                    b_d     = 16'h0;
                    cnt_d   = 7'd0;
                end
            end
            MIX: begin
                s_d[i_q] = a_n;
                l_d[j_q] = b_n;
                a_d      = a_n;
                b_d      = b_n;
                i_d      = (i_q == t_q - 6'd1) ? 6'd0 : i_q + 6'd1;
                j_d      = j_q + 3'd1;
                cnt_d    = cnt_q + 7'd1;
                state_d  = (cnt_q == n_q - 7'd1) ? FIN : MIX;
            end
            FIN: begin
                state_d = IDLE;
                done_d  = 1'b1;
                valid_d = 1'b1;
`ifdef RC5_KEY_ZEROIZE_EN
                l_d     = '{default: '0};
                a_d     = 16'h0;
                b_d     = 16'h0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        s_q <= s_d;
        l_q <= l_d;
        if (!rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            t_q     <= 6'd0;
            n_q     <= 7'd0;
            cnt_q   <= 7'd0;
            i_q     <= 6'd0;
            j_q     <= 3'd0;
            a_q     <= 16'h0;
            b_q     <= 16'h0;
            rd_q    <= 16'h0;
`ifdef RC5_KEY_ZEROIZE_EN
            s_q     <= '{default: '0};
            l_q     <= '{default: '0};
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            t_q     <= t_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            i_q     <= i_d;
            j_q     <= j_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rd_q    <= rd_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign sk_valid   = valid_q;
    assign sk_count   = t_q;
    assign sk_rd_data = rd_q;
endmodule

// File: tb/tb_rc5_key_expander.sv
// tb_rc5_key_expander: randomized scoreboard bench; expected tables come from a plain RC5-16 key-schedule model.
module tb_rc5_key_expander;
    logic         clk, rst, start, busy, done, sk_valid;
    logic [127:0] key;
    logic [4:0]   num_rounds;
    logic [5:0]   sk_count, sk_rd_addr;
    logic [15:0]  sk_rd_data;

    typedef struct {
        logic [15:0] s [34];
        int t;
        int n;
        int s0;
    } exp_t;

    exp_t sb[$];
    int cyc = 0, checks = 0, errors = 0, done_cnt = 0;
    int issued = 0, checked = 0, zero_req = 0, zero_seen = 0, timeouts = 0;
    bit fin_req = 0, rst_edge = 0;

    rc5_key_expander dut (
        .clk(clk), .rst(rst), .start(start), .key(key), .num_rounds(num_rounds),
        .busy(busy), .done(done), .sk_valid(sk_valid), .sk_count(sk_count),
        .sk_rd_addr(sk_rd_addr), .sk_rd_data(sk_rd_data)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rst_edge <= !rst;
    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    function automatic logic [15:0] rl(input logic [15:0] x, input int s);
        int v;
        v = int'(x);
        return 16'(((v << s) | (v >> (16 - s))) & 32'hFFFF);
    endfunction

    function automatic exp_t model(input logic [127:0] k, input int nr);
        exp_t e;
        logic [15:0] S [34];
        logic [15:0] L [8];
        logic [15:0] A, B, ab, sum;
        int r, t, n, i, j;
        r = (nr > 16) ? 16 : nr;
        t = 2 * (r + 1);
        n = 3 * ((t > 8) ? t : 8);
        for (int x = 0; x < 8; x++) L[x] = k[16*x +: 16];
        for (int x = 0; x < 34; x++) S[x] = 16'h0;
        S[0] = 16'hB7E1;
        for (int x = 1; x < t; x++) S[x] = S[x-1] + 16'h9E37;
        A = 0; B = 0; i = 0; j = 0;
        for (int x = 0; x < n; x++) begin
            sum  = S[i] + A + B;
            A    = rl(sum, 3);
            S[i] = A;
            ab   = A + B;
            sum  = L[j] + ab;
            B    = rl(sum, int'(ab) % 16);
            L[j] = B;
            i = (i + 1) % t;
            j = (j + 1) % 8;
        end
        e.s = S; e.t = t; e.n = n; e.s0 = 0;
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: the only process that compares, and the only driver of sk_rd_addr.
    initial begin
        exp_t e;
        sk_rd_addr = 0;
        forever begin
            @(negedge clk);
            if (rst_edge) begin
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_sk_valid", int'(sk_valid), 0);
                chk("rst_sk_count", int'(sk_count), 0);
                chk("rst_rd_data", int'(sk_rd_data), 0);
            end
            if (done) begin
                chk("pending_at_done", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("latency", cyc - e.s0, e.t + e.n + 2);
                    chk("sk_count", int'(sk_count), e.t);
                    chk("sk_valid_at_done", int'(sk_valid), 1);
                    chk("busy_at_done", int'(busy), 1);
                    for (int a = 0; a <= e.t + 1; a++) begin
                        sk_rd_addr = 6'(a);
                        @(negedge clk);
                        if (a == 0) chk("busy_after_done", int'(busy), 0);
                        chk($sformatf("S[%0d]", a), int'(sk_rd_data), (a < e.t) ? int'(e.s[a]) : 0);
                    end
                    sk_rd_addr = 6'd63;
                    @(negedge clk);
                    chk("S[63]", int'(sk_rd_data), 0);
                end
                checked++;
            end
            if (zero_seen != zero_req) begin
                for (int a = 0; a < 34; a++) begin
                    sk_rd_addr = 6'(a);
                    @(negedge clk);
                    chk($sformatf("post_rst_S[%0d]", a), int'(sk_rd_data), 0);
                end
                zero_seen++;
            end
            if (fin_req) begin
                chk("scoreboard_empty", sb.size(), 0);
                chk("done_pulses", done_cnt, issued);
                chk("timeouts", timeouts, 0);
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

    function automatic logic [127:0] rkey();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic wait_checked();
        int k = 0;
        while (checked != issued && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) timeouts++;
    endtask

    task automatic wait_zero();
        int k = 0;
        zero_req++;
        while (zero_seen != zero_req && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) timeouts++;
    endtask

    task automatic run(input logic [127:0] k, input int nr, input bit hammer);
        exp_t e;
        int g = 0;
        @(negedge clk);
        key = k;
        num_rounds = 5'(nr);
        start = 1;
        e = model(k, nr);
        e.s0 = cyc;
        sb.push_back(e);
        issued++;
        if (!hammer) begin
            @(negedge clk);
            start = 0;
            key = rkey();
            num_rounds = 5'($urandom_range(0, 31));
        end else begin
            do begin
                @(negedge clk);
                key = rkey();
                num_rounds = 5'($urandom_range(0, 31));
                g++;
            end while (!done && g < 500);
            if (g >= 500) timeouts++;
            start = 0;
        end
        wait_checked();
    endtask

    initial begin
        rst = 0; start = 0; key = '0; num_rounds = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        wait_zero();
        run(128'h0, 0, 0);
        run(128'h0F0E0D0C0B0A09080706050403020100, 12, 0);
        run(rkey(), 16, 0);
        run(rkey(), 5, 1);
        // abort in the middle of MIX, then prove a fresh expansion is unaffected
        @(negedge clk);
        key = rkey(); num_rounds = 5'd4; start = 1;
        @(negedge clk);
        start = 0;
        repeat (20) @(negedge clk);
        rst = 0;
        @(negedge clk);
        rst = 1;
        wait_zero();
        run(rkey(), 4, 0);
        run(rkey(), 31, 0);
        for (int x = 0; x < 4; x++) run(rkey(), int'($urandom_range(0, 31)), 0);
        fin_req = 1;
        forever @(negedge clk);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
